// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - fetch unit bus: imem read port, decode handshake, redirect
interface instruction_fetch_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    modport master (
        input  redirect_valid, redirect_pc, imem_data, inst_ready,
        output imem_addr, inst_valid, inst_data, inst_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_data, inst_ready,
        input  imem_addr, inst_valid, inst_data, inst_pc
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC sequencer with 1-cycle imem reads and buffered decode handshake
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    instruction_fetch_unit_if.master      bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [31:0]      fetch_pc;
    logic [31:0]      inflight_pc;
    logic             inflight;
    logic [31:0]      fifo_data [FIFO_DEPTH];
    logic [31:0]      fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] free_slots;
    logic             pop;
    logic             push;
    logic             issue;

    // A read is only issued when a slot is guaranteed for its response,
    // counting the outstanding read and the slot freed by this cycle's pop.
    always_comb begin
        pop        = (count != '0) && bus.inst_ready;
        free_slots = DEPTH_C - count + CNT_W'(pop);
        issue      = !bus.redirect_valid && (free_slots > CNT_W'(inflight));
        push       = inflight && !bus.redirect_valid;
    end

    assign bus.imem_addr  = fetch_pc;
    assign bus.inst_valid = (count != '0);
    assign bus.inst_data  = fifo_data[rd_ptr];
    assign bus.inst_pc    = fifo_pc[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (issue) begin
                inflight    <= 1'b1;
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
            end else begin
                inflight <= 1'b0;
            end
        end
    end

    // Buffer storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo_data[wr_ptr] <= bus.imem_data;
            fifo_pc[wr_ptr]   <= inflight_pc;
        end
    end
endmodule
